wrr_sched: RTL
==============

Name: wrr_sched

Overview:
Parametrised weighted-round-robin scheduler for the output stage of the shared-cache switch. It is the successor to the fixed-priority WRR selector and adds the following:
- rotating start pointer
- registered grant with valid/ready handshake
- shadow weight register loaded on demand
- optional packet-hold mode, where one grant covers a full packet and the port is released on eop_in

One instance per output port; SELF_NUB excludes the instance's own input port.

Parameters:
PORT_NUB, 8, number of requesting input ports (>=2)
WEIGHT_W, 3, width of each weight/credit counter; max weight 2^WEIGHT_W-1
SELF_NUB, 0, input port never granted; set >= PORT_NUB to disable exclusion
PKT_MODE, 1, 0 = one grant per word, 1 = grant held until eop_in

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_in  in  PORT_NUB  per-port request, level
weight_in  in  PORT_NUB*WEIGHT_W  weights, port i at [(i+1)*WEIGHT_W-1 : i*WEIGHT_W]
weight_load  in  1  capture weight_in into shadow register
grant_valid  out  1  grant offered
grant_ready  in  1  downstream accepts grant
grant_port  out  $clog2(PORT_NUB)  granted port index
grant_onehot  out  PORT_NUB  one-hot of grant_port, qualified by grant_valid
eop_in  in  1  end of packet for current grant (PKT_MODE=1 only)
busy  out  1  packet in progress (HOLD state)
round_done  out  1  one-cycle pulse when credits reload

Behaviour:
Reset values:
- grant_valid=0, grant_port=0, grant_onehot=0, busy=0, round_done=0, ptr=0.
- Shadow weights = 1 for every port except SELF_NUB, which is 0. Credits = shadow values.

Shadow weight register:
- weight_load: shadow <= weight_in in the next cycle. Slot SELF_NUB is always forced to 0.
- Credits are not altered by weight_load.
- If weight_load coincides with a reload, the reload takes the new weight_in values (bypass).

Eligibility: elig[i] = req_in[i] & (credit[i]!=0) & (i!=SELF_NUB).

State machine, states IDLE, GRANT, HOLD:
- IDLE, elig!=0: select the first elig index at or above ptr, wrapping modulo PORT_NUB. Register it into grant_port and set grant_valid=1 on the next edge. Go to GRANT. Latency is req to grant_valid = 1 cycle.
- IDLE, elig==0 and (req_in & ~self)!=0: reload all credits from shadow, pulse round_done, stay in IDLE. Total latency in this case = 2 cycles.
  - If all requesters have shadow weight 0, reload repeats every cycle and no grant is issued.
- IDLE, no requests: hold; no reload.
- GRANT: grant_valid, grant_port and grant_onehot are stable until grant_ready. The grant is never revoked, even if req_in drops.
  - On handshake: credit[g] decrements by 1, saturating at 0.
  - ptr <= g if the post-decrement credit is nonzero, otherwise ptr <= (g+1) mod PORT_NUB, so a port is served weight times consecutively.
  - grant_valid <= 0 on the handshake edge.
  - PKT_MODE=0: next state is IDLE.
  - PKT_MODE=1: eop_in on the handshake cycle means IDLE (single-word packet); otherwise HOLD.
- HOLD: busy=1, grant_valid=0, grant_port holds g.
  - eop_in=1: busy <= 0, go to IDLE. No new grant is issued in the same cycle as eop.
- eop_in outside GRANT/HOLD, or with PKT_MODE=0, is ignored.

Back-to-back throughput:
- PKT_MODE=0 issues at most one grant every 2 cycles (IDLE then GRANT).
- Credits only change on handshake, on reload, or on reset.

Reset mid-operation: all state returns immediately to the reset values, including in HOLD; the shadow weights are lost.

Arithmetic: ptr and grant_port are $clog2(PORT_NUB) bits. Wrap is mod PORT_NUB, which also holds for non-power-of-2 counts.

Test Plan:
1. PORT_NUB=4, SELF_NUB=0, PKT_MODE=0, weights {1,3,2,0}, all req=1, grant_ready=1 → grant sequence 1,1,1,2,2, round_done, then 1,1,1,2,2. Ports 0 and 3 are never granted.
2. Reset defaults, req_in=4'b1010, grant_ready=1 → grants alternate 1,3,1,3, with a round_done after each pair (round-robin with weights 1).
3. PKT_MODE=1, grant to port 2, eop_in 5 cycles after handshake → busy=1 for 5 cycles, no grant_valid during HOLD; next grant appears 1 cycle after IDLE is re-entered.
4. Handshake with eop_in=1 at the same edge → HOLD is never entered and busy stays 0.
5. grant_ready held low 10 cycles while req_in drops → grant_valid and grant_port stay stable for all 10 cycles and the credit is decremented only at the eventual accept.
6. weight_load of {7,7,7,7} mid-round → current credits are unchanged. The next round_done reloads 7s. weight_load coinciding with a reload cycle → credits equal the new weight_in. rst asserted during GRANT → grant_valid=0 on the same cycle (asynchronous reset).

Source files
------------

// File: rtl/wrr_sched_if.sv
// Request/grant bundle between one wrr_sched instance and its output-port logic.
// The master side is the scheduler; the slave side is the requesting and consuming logic.
interface wrr_sched_if #(
    parameter int unsigned PORT_NUB = 8,
    parameter int unsigned WEIGHT_W = 3
);
    localparam int unsigned PTR_W = $clog2(PORT_NUB);

    logic [PORT_NUB-1:0]          req_in;
    logic [PORT_NUB*WEIGHT_W-1:0] weight_in;
    logic                         weight_load;
    logic                         grant_valid;
    logic                         grant_ready;
    logic [PTR_W-1:0]             grant_port;
    logic [PORT_NUB-1:0]          grant_onehot;
    logic                         eop_in;
    logic                         busy;
    logic                         round_done;

    modport master (
        input  req_in, weight_in, weight_load, grant_ready, eop_in,
        output grant_valid, grant_port, grant_onehot, busy, round_done
    );

    modport slave (
        output req_in, weight_in, weight_load, grant_ready, eop_in,
        input  grant_valid, grant_port, grant_onehot, busy, round_done
    );
endinterface

// File: rtl/wrr_sched.sv
// Weighted-round-robin grant scheduler for one output port. It uses per-port credits and a
// rotating start pointer, and can hold the grant until end of packet.
module wrr_sched #(
    parameter int unsigned PORT_NUB = 8,
    parameter int unsigned WEIGHT_W = 3,
    parameter int unsigned SELF_NUB = 0,
    parameter int unsigned PKT_MODE = 1
) (
    input  logic        clk,
    input  logic        rst,
    wrr_sched_if.master bus
);
    localparam int unsigned      PTR_W     = $clog2(PORT_NUB);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORT_NUB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WEIGHT_W-1:0] r_shadow [PORT_NUB];
    logic [WEIGHT_W-1:0] r_credit [PORT_NUB];
    logic [WEIGHT_W-1:0] w_weight [PORT_NUB];

    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant_port;
    logic [PTR_W-1:0]    w_port_nxt;
    logic [PTR_W-1:0]    w_sel;
    logic [PTR_W-1:0]    w_ptr_inc;
    logic [PORT_NUB-1:0] r_grant_onehot;
    logic [PORT_NUB-1:0] w_onehot_nxt;
    logic [PORT_NUB-1:0] w_elig;
    logic [PORT_NUB-1:0] w_other_req;
    logic [WEIGHT_W-1:0] w_cred_g;
    logic [WEIGHT_W-1:0] w_cred_dec;
    logic                r_grant_valid;
    logic                w_valid_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_round_done;
    logic                w_reload;
    logic                w_hs;
    logic                w_sel_found;
    int unsigned         w_scan;

    // Per-port weight unpack with the self slot forced to zero, plus eligibility.
    always_comb begin
        for (int unsigned i = 0; i < PORT_NUB; i++) begin
            w_weight[i]    = (i == SELF_NUB) ? '0 : bus.weight_in[i*WEIGHT_W +: WEIGHT_W];
            w_other_req[i] = bus.req_in[i] & (i != SELF_NUB);
            w_elig[i]      = w_other_req[i] & (r_credit[i] != '0);
        end
    end

    // The first eligible port at or above the pointer wins. The scan wraps modulo PORT_NUB.
    always_comb begin
        w_sel       = '0;
        w_sel_found = 1'b0;
        w_scan      = 0;
        for (int unsigned k = 0; k < PORT_NUB; k++) begin
            w_scan = 32'(r_ptr) + k;
            if (w_scan >= PORT_NUB) w_scan = w_scan - PORT_NUB;
            if (!w_sel_found && w_elig[PTR_W'(w_scan)]) begin
                w_sel_found = 1'b1;
                w_sel       = PTR_W'(w_scan);
            end
        end
    end

    assign w_cred_g   = r_credit[r_grant_port];
    assign w_cred_dec = (w_cred_g != '0) ? w_cred_g - WEIGHT_W'(1) : '0;
    assign w_ptr_inc  = (r_grant_port == LAST_PORT) ? '0 : r_grant_port + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_sel_found) w_state_nxt = S_GRANT;
            S_GRANT: begin
                if (bus.grant_ready)
                    w_state_nxt = ((PKT_MODE != 0) && !bus.eop_in) ? S_HOLD : S_IDLE;
            end
            S_HOLD:  if (bus.eop_in) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs, plus the reload and handshake strobes.
    always_comb begin
        w_valid_nxt  = r_grant_valid;
        w_port_nxt   = r_grant_port;
        w_busy_nxt   = 1'b0;
        w_reload     = 1'b0;
        w_hs         = 1'b0;
        w_onehot_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_valid_nxt = 1'b1;
                    w_port_nxt  = w_sel;
                end else if (w_other_req != '0) begin
                    w_reload = 1'b1;
                end
            end
            S_GRANT: begin
                if (bus.grant_ready) begin
                    w_hs        = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = (PKT_MODE != 0) && !bus.eop_in;
                end
            end
            S_HOLD:  w_busy_nxt = !bus.eop_in;
            default: w_valid_nxt = 1'b0;
        endcase
        for (int unsigned i = 0; i < PORT_NUB; i++)
            w_onehot_nxt[i] = w_valid_nxt && (w_port_nxt == PTR_W'(i));
    end

    // Outputs, pointer, credits and shadow weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_valid  <= 1'b0;
            r_grant_port   <= '0;
            r_grant_onehot <= '0;
            r_busy         <= 1'b0;
            r_round_done   <= 1'b0;
            r_ptr          <= '0;
            for (int unsigned i = 0; i < PORT_NUB; i++) begin
                r_shadow[i] <= (i == SELF_NUB) ? '0 : WEIGHT_W'(1);
                r_credit[i] <= (i == SELF_NUB) ? '0 : WEIGHT_W'(1);
            end
        end else begin
            r_grant_valid  <= w_valid_nxt;
            r_grant_port   <= w_port_nxt;
            r_grant_onehot <= w_onehot_nxt;
            r_busy         <= w_busy_nxt;
            r_round_done   <= w_reload;
            // A port keeps the pointer while it still has credit, so it is served weight times in a row.
            if (w_hs) r_ptr <= (w_cred_dec != '0) ? r_grant_port : w_ptr_inc;
            for (int unsigned i = 0; i < PORT_NUB; i++) begin
                if (bus.weight_load) r_shadow[i] <= w_weight[i];
                if (w_reload)
                    r_credit[i] <= bus.weight_load ? w_weight[i] : r_shadow[i];
                else if (w_hs && (r_grant_port == PTR_W'(i)))
                    r_credit[i] <= w_cred_dec;
            end
        end
    end

    assign bus.grant_valid  = r_grant_valid;
    assign bus.grant_port   = r_grant_port;
    assign bus.grant_onehot = r_grant_onehot;
    assign bus.busy         = r_busy;
    assign bus.round_done   = r_round_done;
endmodule
